// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM (IF/ID/EX/MEM/WB) with variable-latency IM/DM handshakes and retired-instruction counter.
// Outputs are combinational from state; define ILLEGAL_TRAP_EN to trap on illegal instructions instead of retiring them as NOPs.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       instr,
  input  logic              z,
  input  logic              im_ready,
  input  logic              dm_ready,
  output logic              im_req,
  output logic              ir_we,
  output logic              pc_we,
  output logic [1:0]        pc_sel,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  output logic [4:0]        rf_wa,
  output logic              rf_we,
  output logic              rf_wdsel,
  output logic              mdr_we,
  output logic [3:0]        alu_op,
  output logic              alu_bsel,
  output logic              imm_sext,
  output logic              dm_req,
  output logic              dm_we,
  output logic              bus_err,
  output logic              trap,
  output logic [2:0]        state,
  output logic [PERF_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_SLL = 4'b1111;

  // The abort fires in the MEM_TIMEOUT-th waiting cycle, i.e. when the count of
  // cycles already waited reaches MEM_TIMEOUT-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic [PERF_W-1:0] instret_q, instret_d;

  logic [5:0] opcode, funct;
  logic       is_r, is_addu, is_subu, is_sll, is_ori;
  logic       is_beq, is_bne, is_j, is_lw, is_sw, is_legal;
  logic       retire;

  logic im_req_c, ir_we_c, pc_we_c, rf_we_c, mdr_we_c;
  logic dm_req_c, dm_we_c, bus_err_c;
  logic unused_shamt;

  assign opcode   = instr[31:26];
  assign funct    = instr[5:0];
  assign is_r     = (opcode == 6'b000000);
  assign is_addu  = is_r && (funct == 6'b100001);
  assign is_subu  = is_r && (funct == 6'b100011);
  assign is_sll   = is_r && (funct == 6'b000000);
  assign is_ori   = (opcode == 6'b001101);
  assign is_beq   = (opcode == 6'b000100);
  assign is_bne   = (opcode == 6'b000101);
  assign is_j     = (opcode == 6'b000010);
  assign is_lw    = (opcode == 6'b100011);
  assign is_sw    = (opcode == 6'b101011);
  assign is_legal = is_addu | is_subu | is_sll | is_ori | is_beq | is_bne |
                    is_j | is_lw | is_sw;

  // shamt is consumed by the datapath shifter, not by control
  assign unused_shamt = ^instr[10:6];

  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];
  assign rf_wa   = is_r ? instr[15:11] : instr[20:16];

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    retire    = 1'b0;
    im_req_c  = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    pc_sel    = 2'd0;
    rf_we_c   = 1'b0;
    rf_wdsel  = 1'b0;
    mdr_we_c  = 1'b0;
    alu_op    = ALU_ADD;
    alu_bsel  = 1'b0;
    imm_sext  = 1'b0;
    dm_req_c  = 1'b0;
    dm_we_c   = 1'b0;
    bus_err_c = 1'b0;

    case (state_q)
      S_IF: begin
        im_req_c = 1'b1;
        if (im_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = S_ID;
        end
      end

      S_ID: begin
        if (is_j) begin
          pc_we_c = 1'b1;
          pc_sel  = 2'd2;
          retire  = 1'b1;
          state_d = S_IF;
        end else if (is_legal) begin
          state_d = S_EX;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          retire  = 1'b1;
          state_d = S_IF;
`endif
        end
      end

      S_EX: begin
        if (is_beq || is_bne) begin
          alu_op   = ALU_SUB;
          imm_sext = 1'b1;
          pc_sel   = 2'd1;
          pc_we_c  = (is_beq & z) | (is_bne & ~z);
          retire   = 1'b1;
          state_d  = S_IF;
        end else if (is_lw || is_sw) begin
          alu_op   = ALU_ADD;
          alu_bsel = 1'b1;
          imm_sext = 1'b1;
          state_d  = S_MEM;
        end else begin
          if (is_subu)     alu_op = ALU_SUB;
          else if (is_sll) alu_op = ALU_SLL;
          else if (is_ori) alu_op = ALU_OR;
          else             alu_op = ALU_ADD;
          alu_bsel = is_ori;
          state_d  = S_WB;
        end
      end

      S_MEM: begin
        dm_req_c = 1'b1;
        dm_we_c  = is_sw;
        if (dm_ready) begin
          if (is_lw) begin
            mdr_we_c = 1'b1;
            state_d  = S_WB;
          end else begin
            retire  = 1'b1;
            state_d = S_IF;
          end
        end else if (cnt_q == TO_LAST) begin
          bus_err_c = 1'b1;
          state_d   = S_IF;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      S_WB: begin
        rf_we_c  = 1'b1;
        rf_wdsel = is_lw;
        retire   = 1'b1;
        state_d  = S_IF;
      end

`ifdef ILLEGAL_TRAP_EN
      S_TRAP: state_d = S_TRAP;
`endif

      default: state_d = S_IF;
    endcase
  end

  assign instret_d = retire ? instret_q + PERF_W'(1) : instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      cnt_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end

  // Strobes are gated by rst_n so nothing fires while reset is held, even in IF.
  assign im_req  = im_req_c  & rst_n;
  assign ir_we   = ir_we_c   & rst_n;
  assign pc_we   = pc_we_c   & rst_n;
  assign rf_we   = rf_we_c   & rst_n;
  assign mdr_we  = mdr_we_c  & rst_n;
  assign dm_req  = dm_req_c  & rst_n;
  assign dm_we   = dm_we_c   & rst_n;
  assign bus_err = bus_err_c & rst_n;

`ifdef ILLEGAL_TRAP_EN
  assign trap = (state_q == S_TRAP) & rst_n;
`else
  assign trap = 1'b0;
`endif

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed test-plan steps then random instructions,
// each checked cycle by cycle against a per-instruction phase timeline built from the ISA rules.
module tb_multicycle_control;

  localparam int MT = 16;
  localparam int TW = 5;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   instr = '0;
  logic          z = 1'b0, im_ready = 1'b0, dm_ready = 1'b0;
  logic          im_req, ir_we, pc_we, rf_we, rf_wdsel, mdr_we;
  logic [1:0]    pc_sel;
  logic [4:0]    rs_addr, rt_addr, rf_wa;
  logic [3:0]    alu_op;
  logic          alu_bsel, imm_sext, dm_req, dm_we, bus_err, trap;
  logic [2:0]    state;
  logic [PW-1:0] instret;

  multicycle_control #(.MEM_TIMEOUT(MT), .TO_W(TW), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .z(z),
    .im_ready(im_ready), .dm_ready(dm_ready),
    .im_req(im_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rf_wa(rf_wa), .rf_we(rf_we),
    .rf_wdsel(rf_wdsel), .mdr_we(mdr_we), .alu_op(alu_op), .alu_bsel(alu_bsel),
    .imm_sext(imm_sext), .dm_req(dm_req), .dm_we(dm_we), .bus_err(bus_err),
    .trap(trap), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int model_ret = 0;

  typedef enum int {K_ADDU, K_SUBU, K_SLL, K_ORI, K_BEQ, K_BNE, K_J, K_LW, K_SW, K_ILL} kind_e;
  typedef struct {int ph; bit last; bit rdy; bit tmo;} step_t;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic kind_e kind_of(input logic [31:0] i);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    case (op)
      6'h00: kind_of = (fn == 6'h21) ? K_ADDU : (fn == 6'h23) ? K_SUBU :
                       (fn == 6'h00) ? K_SLL : K_ILL;
      6'h0d: kind_of = K_ORI;
      6'h04: kind_of = K_BEQ;
      6'h05: kind_of = K_BNE;
      6'h02: kind_of = K_J;
      6'h23: kind_of = K_LW;
      6'h2b: kind_of = K_SW;
      default: kind_of = K_ILL;
    endcase
  endfunction

  // Execute one instruction from its IF cycle; imw = IM wait cycles, dmw = DM wait cycles.
  task automatic run_instr(input string nm, input logic [31:0] ins, input logic zz,
                           input int imw, input int dmw);
    step_t tl[$];
    kind_e k;
    bit retires, br, taken;
    logic [14:0] expv, obsv;
    logic [1:0] sel;
    logic [2:0] st;
    k = kind_of(ins);
    retires = 1'b1;
    for (int i = 0; i <= imw; i++) tl.push_back('{0, i == imw, 1'b0, 1'b0});
    tl.push_back('{1, 1'b1, 1'b0, 1'b0});
    case (k)
      K_J: ;
      K_ILL: begin
`ifdef ILLEGAL_TRAP_EN
        retires = 1'b0;
        for (int i = 0; i < 4; i++) tl.push_back('{5, 1'b0, 1'b0, 1'b0});
`endif
      end
      K_BEQ, K_BNE: tl.push_back('{2, 1'b1, 1'b0, 1'b0});
      K_LW, K_SW: begin
        tl.push_back('{2, 1'b1, 1'b0, 1'b0});
        if (dmw < MT) begin
          for (int i = 0; i <= dmw; i++) tl.push_back('{3, i == dmw, i == dmw, 1'b0});
          if (k == K_LW) tl.push_back('{4, 1'b1, 1'b0, 1'b0});
        end else begin
          for (int i = 0; i < MT; i++) tl.push_back('{3, i == MT - 1, 1'b0, i == MT - 1});
          retires = 1'b0;
        end
      end
      default: begin
        tl.push_back('{2, 1'b1, 1'b0, 1'b0});
        tl.push_back('{4, 1'b1, 1'b0, 1'b0});
      end
    endcase

    br    = (k == K_BEQ) || (k == K_BNE);
    taken = ((k == K_BEQ) && zz) || ((k == K_BNE) && !zz);
    foreach (tl[n]) begin
      instr    = (tl[n].ph == 0) ? $urandom : ins;
      z        = (tl[n].ph == 2) ? zz : 1'($urandom);
      im_ready = (tl[n].ph == 0) && tl[n].last;
      dm_ready = tl[n].rdy;
      @(negedge clk);
      sel = (tl[n].ph == 1 && k == K_J) ? 2'd2 : (tl[n].ph == 2 && br) ? 2'd1 : 2'd0;
      st  = tl[n].ph[2:0];
      expv = {tl[n].ph == 0, tl[n].ph == 0 && tl[n].last,
              (tl[n].ph == 0 && tl[n].last) || (tl[n].ph == 1 && k == K_J) || (tl[n].ph == 2 && taken),
              sel, tl[n].ph == 4, tl[n].ph == 4 && k == K_LW,
              tl[n].ph == 3 && k == K_LW && tl[n].rdy, tl[n].ph == 3,
              tl[n].ph == 3 && k == K_SW, tl[n].tmo, tl[n].ph == 5, st};
      obsv = {im_req, ir_we, pc_we, pc_sel, rf_we, rf_wdsel, mdr_we, dm_req, dm_we,
              bus_err, trap, state};
      chk({nm, ".ctl"}, obsv, expv);
      if (tl[n].ph == 1) chk({nm, ".rs_rt"}, {rs_addr, rt_addr}, {ins[25:21], ins[20:16]});
      if (tl[n].ph == 2) begin
        case (k)
          K_ADDU:      chk({nm, ".ex"}, {alu_op, alu_bsel}, {4'b0000, 1'b0});
          K_SUBU:      chk({nm, ".ex"}, {alu_op, alu_bsel}, {4'b0001, 1'b0});
          K_SLL:       chk({nm, ".ex"}, alu_op, 4'b1111);
          K_ORI:       chk({nm, ".ex"}, {alu_op, alu_bsel, imm_sext}, {4'b0101, 2'b10});
          K_LW, K_SW:  chk({nm, ".ex"}, {alu_op, alu_bsel, imm_sext}, {4'b0000, 2'b11});
          K_BEQ, K_BNE: chk({nm, ".ex"}, {alu_op, alu_bsel}, {4'b0001, 1'b0});
          default: ;
        endcase
      end
      if (tl[n].ph == 4)
        chk({nm, ".rf_wa"}, rf_wa, (k == K_LW || k == K_ORI) ? ins[20:16] : ins[15:11]);
      @(posedge clk);
      #1;
    end
    if (retires) model_ret = (model_ret + 1) % (1 << PW);
    chk({nm, ".instret"}, instret, model_ret);
    if (k != K_ILL || retires) chk({nm, ".back_to_if"}, state, 3'd0);
    else chk({nm, ".stuck_trap"}, {state, trap}, {3'd5, 1'b1});
  endtask

  function automatic logic [31:0] rnd_instr(input int sel);
    logic [4:0] rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
    imm = 16'($urandom); tgt = 26'($urandom);
    case (sel)
      0: rnd_instr = {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1: rnd_instr = {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2: rnd_instr = {6'h00, 5'd0, rt, rd, sh, 6'h00};
      3: rnd_instr = {6'h0d, rs, rt, imm};
      4: rnd_instr = {6'h04, rs, rt, imm};
      5: rnd_instr = {6'h05, rs, rt, imm};
      6: rnd_instr = {6'h02, tgt};
      7: rnd_instr = {6'h23, rs, rt, imm};
      8: rnd_instr = {6'h2b, rs, rt, imm};
      default: rnd_instr = {6'h00, rs, rt, rd, 5'd0, 6'h20};
    endcase
  endfunction

  initial begin
    int nsel;
    // Reset held: strobes quiet, state and counter at zero.
    #12;
    chk("reset.outs", {im_req, ir_we, pc_we, rf_we, mdr_we, dm_req, dm_we, bus_err, trap},
        9'd0);
    chk("reset.state", {state, pc_sel, alu_op}, 9'd0);
    chk("reset.instret", instret, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr("addu", 32'h00221821, 1'b0, 0, 0);
    run_instr("ori",  32'h34051234, 1'b0, 0, 0);
    run_instr("lw_wait3", 32'h8C240008, 1'b0, 0, 3);
    run_instr("beq_z1", 32'h10220004, 1'b1, 0, 0);
    run_instr("beq_z0", 32'h10220004, 1'b0, 0, 0);
    run_instr("bne_z1", 32'h14220004, 1'b1, 0, 0);
    run_instr("bne_z0", 32'h14220004, 1'b0, 0, 0);
    run_instr("sw_timeout", 32'hAC240000, 1'b0, 0, 100);
    run_instr("sw_edge_ok", 32'hAC240000, 1'b0, 1, MT - 1);
    run_instr("j", 32'h08000010, 1'b0, 2, 0);

    // Reset asserted while sw sits in MEM.
    instr = 32'hAC240000; im_ready = 1'b1; dm_ready = 1'b0;
    @(posedge clk); #1 im_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midmem.dm_req_before", {dm_req, state}, {1'b1, 3'd3});
    rst_n = 1'b0;
    #1;
    chk("midmem.dm_req_after", {dm_req, dm_we, im_req, state}, {3'b000, 3'd0});
    chk("midmem.instret", instret, 0);
    model_ret = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
`ifdef ILLEGAL_TRAP_EN
      nsel = $urandom_range(0, 8);
`else
      nsel = $urandom_range(0, 9);
`endif
      run_instr("rand", rnd_instr(nsel), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, MT + 2));
    end

    run_instr("illegal", 32'hFC000000, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
